// File: rtl/dpram_be_clr.sv
// Single-clock true dual-port RAM with per-lane write enables, selectable read-during-write
// behaviour, optional output register and a post-reset clear sweep.
module dpram_be_clr #(
    parameter int unsigned addr_width_g     = 10,
    parameter int unsigned data_width_g     = 16,
    parameter int unsigned byte_width_g     = 8,
    parameter int unsigned read_first_g     = 0,
    parameter int unsigned out_reg_g        = 0,
    parameter int unsigned clear_on_reset_g = 1,
    parameter logic [data_width_g-1:0] clear_value_g = '0
) (
    input  logic                                   clock,
    input  logic                                   reset_n,
    input  logic                                   wren_a,
    input  logic [addr_width_g-1:0]                address_a,
    input  logic [data_width_g-1:0]                data_a,
    input  logic [data_width_g/byte_width_g-1:0]   byteena_a,
    output logic [data_width_g-1:0]                q_a,
    input  logic                                   wren_b,
    input  logic [addr_width_g-1:0]                address_b,
    input  logic [data_width_g-1:0]                data_b,
    input  logic [data_width_g/byte_width_g-1:0]   byteena_b,
    output logic [data_width_g-1:0]                q_b,
    output logic                                   init_busy
);

    localparam int unsigned NB    = data_width_g / byte_width_g;
    localparam int unsigned DEPTH = 32'(1) << addr_width_g;

    generate
        if ((data_width_g % byte_width_g) != 0) begin : g_bad_width
            $error("dpram_be_clr: data_width_g must be a multiple of byte_width_g");
        end
    endgenerate

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t                    state_q;
    logic [addr_width_g-1:0]   cnt_q;
    logic                      busy_q;
    logic [data_width_g-1:0]   rd_a_q, rd_b_q, out_a_q, out_b_q;
    logic [data_width_g-1:0]   rd_a_d, rd_b_d;
    logic [data_width_g-1:0]   old_a, old_b, fin_a, fin_b;
    logic [data_width_g-1:0]   mem [DEPTH];

    function automatic logic [data_width_g-1:0] merge_lanes(
        input logic [data_width_g-1:0] base,
        input logic [data_width_g-1:0] wdata,
        input logic [NB-1:0]           be
    );
        logic [data_width_g-1:0] r;
        r = base;
        for (int i = 0; i < int'(NB); i++) begin
            if (be[i]) r[i*byte_width_g +: byte_width_g] = wdata[i*byte_width_g +: byte_width_g];
        end
        return r;
    endfunction

    // Post-write word at each port's address: B lanes first, A overrides on shared lanes
    always_comb begin
        old_a  = mem[address_a];
        old_b  = mem[address_b];
        fin_a  = old_a;
        fin_b  = old_b;
        rd_a_d = '0;
        rd_b_d = '0;
        if (wren_b && (address_b == address_a)) fin_a = merge_lanes(fin_a, data_b, byteena_b);
        if (wren_a) fin_a = merge_lanes(fin_a, data_a, byteena_a);
        if (wren_b) fin_b = merge_lanes(fin_b, data_b, byteena_b);
        if (wren_a && (address_a == address_b)) fin_b = merge_lanes(fin_b, data_a, byteena_a);
        if (state_q == ST_RUN) begin
            rd_a_d = ((read_first_g != 0) || !wren_a) ? old_a : fin_a;
            rd_b_d = ((read_first_g != 0) || !wren_b) ? old_b : fin_b;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= (clear_on_reset_g != 0) ? ST_CLEAR : ST_RUN;
            busy_q  <= (clear_on_reset_g != 0);
            cnt_q   <= '0;
            rd_a_q  <= '0;
            rd_b_q  <= '0;
            out_a_q <= '0;
            out_b_q <= '0;
        end else begin
            rd_a_q <= rd_a_d;
            rd_b_q <= rd_b_d;
            case (state_q)
                ST_CLEAR: begin
                    cnt_q   <= cnt_q + addr_width_g'(1);
                    out_a_q <= '0;
                    out_b_q <= '0;
                    if (cnt_q == '1) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    out_a_q <= rd_a_q;
                    out_b_q <= rd_b_q;
                end
            endcase
        end
    end

    // Storage; later assignment gives port A priority on lanes both ports enable
    always_ff @(posedge clock) begin
        if (reset_n) begin
            if (state_q == ST_CLEAR) begin
                mem[cnt_q] <= clear_value_g;
            end else begin
                for (int i = 0; i < int'(NB); i++) begin
                    if (wren_b && byteena_b[i])
                        mem[address_b][i*byte_width_g +: byte_width_g] <= data_b[i*byte_width_g +: byte_width_g];
                    if (wren_a && byteena_a[i])
                        mem[address_a][i*byte_width_g +: byte_width_g] <= data_a[i*byte_width_g +: byte_width_g];
                end
            end
        end
    end

    assign q_a       = (out_reg_g != 0) ? out_a_q : rd_a_q;
    assign q_b       = (out_reg_g != 0) ? out_b_q : rd_b_q;
    assign init_busy = busy_q;

endmodule
